// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver.
// Holds the hex glyph table, the output bit order and small helpers.
package seg7_pkg;

   localparam int SEG_WIDTH = 7;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Canonical glyphs, active high, bit 0 = a ... bit 6 = g
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [SEG_WIDTH-1:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0]           canon;
      logic [SEG_WIDTH-1:0] seg;
      canon = HEX_SEG[nibble];
      seg = '0;
      seg[SEG_A] = canon[0];
      seg[SEG_B] = canon[1];
      seg[SEG_C] = canon[2];
      seg[SEG_D] = canon[3];
      seg[SEG_E] = canon[4];
      seg[SEG_F] = canon[5];
      seg[SEG_G] = canon[6];
      return seg;
   endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot timing for the scanned display: prescaler, digit index,
// PWM lit window and the per-frame snapshot pulse.
module seg7_scan_timer
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DIV          = 50000,
   parameter int GUARD_CYCLES = 64
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [3:0]                       brightness,
   output logic [idx_width(NUM_DIGITS)-1:0] idx,
   output logic                             lit,
   output logic                             snap,
   output logic                             frame_start
);

   localparam int PW = $clog2(DIV);
   localparam int IW = idx_width(NUM_DIGITS);

   logic [PW-1:0] prescaler;
   logic [31:0]   count;
   logic [31:0]   thr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler   <= '0;
         idx         <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= snap;
         if (prescaler == PW'(DIV - 1)) begin
            prescaler <= '0;
            idx       <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
         end else begin
            prescaler <= prescaler + PW'(1);
         end
      end
   end

   // The lit window follows the guard interval and scales with brightness+1 in 1/16 steps.
   always_comb begin
      count = 32'(prescaler);
      thr   = ((32'(brightness) + 32'd1) * 32'(DIV - GUARD_CYCLES)) >> 4;
      snap  = (prescaler == '0) && (idx == '0);
      lit   = (count >= 32'(GUARD_CYCLES)) && (count < 32'(GUARD_CYCLES) + thr);
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed hex display driver: per-frame input snapshot, leading-zero
// blanking, per-digit enables and decimal points, registered pin outputs.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_HZ         = 50000000,
   parameter int SCAN_HZ        = 1000,
   parameter int GUARD_CYCLES   = 64,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] disp_value,
   input  logic [NUM_DIGITS-1:0]   dp_en,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lz_suppress,
   input  logic [3:0]              brightness,
   output logic [6:0]              segments,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   segsel,
   output logic                    frame_start
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int IW  = idx_width(NUM_DIGITS);

   localparam logic [SEG_WIDTH-1:0]  SEG_INV = {SEG_WIDTH{SEG_ACTIVE_LOW != 0}};
   localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] SEL_INV = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};

   logic [4*NUM_DIGITS-1:0] value_s;
   logic [NUM_DIGITS-1:0]   dp_en_s;
   logic [NUM_DIGITS-1:0]   digit_en_s;
   logic                    lz_s;
   logic [3:0]              brightness_s;

   logic [IW-1:0]           idx;
   logic                    lit;
   logic                    snap;

   logic                    zero_above;
   logic [NUM_DIGITS-1:0]   blank;
   logic [3:0]              nibble;
   logic [SEG_WIDTH-1:0]    seg_on;
   logic                    dp_on;
   logic [NUM_DIGITS-1:0]   sel_on;

   seg7_scan_timer #(
      .NUM_DIGITS   (NUM_DIGITS),
      .DIV          (DIV),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .brightness  (brightness_s),
      .idx         (idx),
      .lit         (lit),
      .snap        (snap),
      .frame_start (frame_start)
   );

   // Inputs are sampled once per frame so a frame never mixes old and new values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_s      <= '0;
         dp_en_s      <= '0;
         digit_en_s   <= '0;
         lz_s         <= 1'b0;
         brightness_s <= '0;
      end else if (snap) begin
         value_s      <= disp_value;
         dp_en_s      <= dp_en;
         digit_en_s   <= digit_en;
         lz_s         <= lz_suppress;
         brightness_s <= brightness;
      end
   end

   // A digit is blank when it and every more significant nibble are zero; digit 0 always shows.
   always_comb begin
      zero_above = 1'b1;
      blank      = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (value_s[4*i +: 4] == 4'h0);
         blank[i]   = lz_s & zero_above & (i != 0);
      end
   end

   always_comb begin
      nibble = value_s[4*idx +: 4];
      seg_on = '0;
      dp_on  = 1'b0;
      sel_on = '0;
      if (lit && digit_en_s[idx]) begin
         if (blank[idx]) begin
            dp_on       = dp_en_s[idx];
            sel_on[idx] = dp_en_s[idx];
         end else begin
            seg_on      = hex_to_seg(nibble);
            dp_on       = dp_en_s[idx];
            sel_on[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segments <= SEG_INV;
         dp       <= DP_INV;
         segsel   <= SEL_INV;
      end else begin
         segments <= seg_on ^ SEG_INV;
         dp       <= dp_on ^ DP_INV;
         segsel   <= sel_on ^ SEL_INV;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: cycle-level reference model plus
// table-driven whole-frame checks and reset/timing sequences.
module tb_seg7_scan_display;

   localparam int N     = 4;
   localparam int DIV   = 36;
   localparam int GUARD = 4;
   localparam int FRAME = N * DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] disp_value = '0;
   logic [3:0]  dp_en = '0;
   logic [3:0]  digit_en = '0;
   logic        lz_suppress = 1'b0;
   logic [3:0]  brightness = '0;
   logic [6:0]  segments;
   logic        dp;
   logic [3:0]  segsel;
   logic        frame_start;

   int compared = 0;
   int mismatched = 0;
   bit check_on = 1'b0;

   seg7_scan_display #(
      .NUM_DIGITS     (N),
      .CLK_HZ         (3600),
      .SCAN_HZ        (100),
      .GUARD_CYCLES   (GUARD),
      .SEG_ACTIVE_LOW (1),
      .SEL_ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .disp_value  (disp_value),
      .dp_en       (dp_en),
      .digit_en    (digit_en),
      .lz_suppress (lz_suppress),
      .brightness  (brightness),
      .segments    (segments),
      .dp          (dp),
      .segsel      (segsel),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time since reset release determines slot and phase; pins lag by one clock.
   logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int          s_ref, m_p, m_d, m_thr;
   logic [15:0] val_m;
   logic [3:0]  dp_m, en_m, br_m, m_sel, m_nib;
   logic        lz_m, m_dp;
   logic [6:0]  m_seg;
   logic [12:0] exp_pins = {7'h7F, 1'b1, 4'hF, 1'b0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ref = 0;
         val_m = '0; dp_m = '0; en_m = '0; br_m = '0; lz_m = 1'b0;
         exp_pins = {7'h7F, 1'b1, 4'hF, 1'b0};
      end else begin
         m_p   = s_ref % DIV;
         m_d   = (s_ref / DIV) % N;
         m_thr = (int'(br_m) + 1) * (DIV - GUARD) / 16;
         m_nib = 4'((val_m >> (4 * m_d)) & 16'hF);
         m_seg = '0; m_dp = 1'b0; m_sel = '0;
         if (m_p >= GUARD && m_p < GUARD + m_thr && en_m[m_d]) begin
            if (lz_m && m_d > 0 && (val_m >> (4 * m_d)) == 16'h0) begin
               m_sel[m_d] = dp_m[m_d];
               m_dp = dp_m[m_d];
            end else begin
               m_sel[m_d] = 1'b1;
               m_seg = hex_tab[m_nib];
               m_dp = dp_m[m_d];
            end
         end
         exp_pins = {~m_seg, ~m_dp, ~m_sel, (s_ref % FRAME) == 0};
         if (s_ref % FRAME == 0) begin
            val_m = disp_value; dp_m = dp_en; en_m = digit_en;
            br_m = brightness; lz_m = lz_suppress;
         end
         s_ref++;
      end
   end

   always @(negedge clk) begin
      if (check_on)
         checkOutput("pins", {19'b0, segments, dp, segsel, frame_start}, {19'b0, exp_pins});
   end

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [3:0]  en;
      logic        lz;
      logic [3:0]  br;
      int          chg_at;
      logic [15:0] chg_value;
      logic [3:0]  chg_br;
      logic [3:0]  exp_sel;
      logic [3:0]  exp_dp;
      logic [27:0] exp_seg;
      int          exp_lit;
   } vec_t;

   vec_t vecs [10];

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      disp_value  = v.value;
      dp_en       = v.dp;
      digit_en    = v.en;
      lz_suppress = v.lz;
      brightness  = v.br;
   endtask

   task automatic checkFrame(input vec_t v, input int k);
      logic [3:0]  sel_seen, dp_seen;
      logic [6:0]  seg_seen [4];
      int          lit [4];
      int          extra;
      bit          got;
      logic [31:0] lit_exp;
      sel_seen = '0; dp_seen = '0; extra = 0; got = 1'b0;
      for (int d = 0; d < 4; d++) begin seg_seen[d] = 7'h7F; lit[d] = 0; end
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (frame_start) begin got = 1'b1; break; end
      end
      checkOutput($sformatf("v%0d_frame_found", k), 32'(got), 32'd1);
      for (int c = 0; c < FRAME; c++) begin
         if (c == v.chg_at) begin
            disp_value = v.chg_value;
            brightness = v.chg_br;
         end
         if (c > 0 && frame_start) extra++;
         for (int d = 0; d < 4; d++) begin
            if (!segsel[d]) begin
               sel_seen[d] = 1'b1;
               lit[d]++;
               seg_seen[d] = segments;
               if (!dp) dp_seen[d] = 1'b1;
            end
         end
         @(negedge clk);
      end
      lit_exp = '0;
      for (int d = 0; d < 4; d++) if (v.exp_sel[d]) lit_exp[8*d +: 8] = 8'(v.exp_lit);
      checkOutput($sformatf("v%0d_period", k), {31'(extra), frame_start}, 32'd1);
      checkOutput($sformatf("v%0d_sel", k), 32'(sel_seen), 32'(v.exp_sel));
      checkOutput($sformatf("v%0d_dp", k), 32'(dp_seen), 32'(v.exp_dp));
      checkOutput($sformatf("v%0d_seg", k), 32'({seg_seen[3], seg_seen[2], seg_seen[1], seg_seen[0]}),
                  32'(v.exp_seg));
      checkOutput($sformatf("v%0d_lit", k), {8'(lit[3]), 8'(lit[2]), 8'(lit[1]), 8'(lit[0])}, lit_exp);
   endtask

   task automatic checkPeriodAfterRelease(input string tag);
      int n;
      @(negedge clk);
      checkOutput({tag, "_fs_first"}, 32'(frame_start), 32'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 3 * FRAME);
      checkOutput({tag, "_fs_period"}, 32'(n), 32'(FRAME));
   endtask

   initial begin
      vecs[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, 4'hF, -1, 16'h0,    4'h0, 4'hF, 4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, 32};
      vecs[1] = '{16'h1234, 4'h0, 4'hF, 1'b0, 4'hF, 80, 16'hFFFF, 4'hF, 4'hF, 4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, 32};
      vecs[2] = '{16'hFFFF, 4'h0, 4'hF, 1'b0, 4'hF, -1, 16'h0,    4'h0, 4'hF, 4'h0, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 32};
      vecs[3] = '{16'h0050, 4'h0, 4'hF, 1'b1, 4'hF, -1, 16'h0,    4'h0, 4'h3, 4'h0, {7'h7F, 7'h7F, 7'h12, 7'h40}, 32};
      vecs[4] = '{16'h0000, 4'h0, 4'hF, 1'b1, 4'hF, -1, 16'h0,    4'h0, 4'h1, 4'h0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 32};
      vecs[5] = '{16'h0050, 4'h8, 4'hF, 1'b1, 4'hF, -1, 16'h0,    4'h0, 4'hB, 4'h8, {7'h7F, 7'h7F, 7'h12, 7'h40}, 32};
      vecs[6] = '{16'h1234, 4'h0, 4'hF, 1'b0, 4'h7, -1, 16'h0,    4'h0, 4'hF, 4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, 16};
      vecs[7] = '{16'h1234, 4'h0, 4'hF, 1'b0, 4'hF, 40, 16'h1234, 4'h0, 4'hF, 4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, 32};
      vecs[8] = '{16'h1234, 4'h0, 4'hF, 1'b0, 4'h0, -1, 16'h0,    4'h0, 4'hF, 4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, 2};
      vecs[9] = '{16'h1234, 4'h2, 4'h5, 1'b0, 4'hF, -1, 16'h0,    4'h0, 4'h5, 4'h0, {7'h7F, 7'h24, 7'h7F, 7'h19}, 32};

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_on = 1'b1;
      checkOutput("reset_pins", {19'b0, segments, dp, segsel, frame_start}, {19'b0, 7'h7F, 1'b1, 4'hF, 1'b0});
      disp_value = 16'h1234; digit_en = 4'hF; brightness = 4'hF;
      rst_n = 1'b1;
      checkPeriodAfterRelease("init");

      for (int k = 0; k < 10; k++) begin
         applyStimulus(vecs[k]);
         checkFrame(vecs[k], k);
      end

      begin : mid_slot_reset
         bit seen_lit;
         seen_lit = 1'b0;
         for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            if (segsel != 4'hF) begin seen_lit = 1'b1; break; end
         end
         checkOutput("lit_before_reset", 32'(seen_lit), 32'd1);
         @(posedge clk);
         #2 rst_n = 1'b0;
         #1 checkOutput("async_reset", {19'b0, segments, dp, segsel, frame_start},
                        {19'b0, 7'h7F, 1'b1, 4'hF, 1'b0});
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         checkPeriodAfterRelease("rerun");
      end

      for (int r = 0; r < 25; r++) begin
         @(negedge clk);
         disp_value  = 16'($urandom);
         if ($urandom_range(0, 2) == 0) disp_value = 16'($urandom_range(0, 255));
         dp_en       = 4'($urandom);
         digit_en    = 4'($urandom);
         lz_suppress = 1'($urandom_range(0, 1));
         brightness  = 4'($urandom);
         repeat ($urandom_range(20, 300)) @(negedge clk);
      end

      check_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
